// File: rtl/i2c_target.sv
// i2c_target: oversampled I2C target (slave) answering at 7-bit address ADDR.
// scl and sda are sampled through a synchronizer plus a history flop running
// on I_clk; all bus decisions are made from the resulting edge strobes.
// The target never stretches scl and only ever pulls sda low or releases it.
//
// Ports:
//   I_clk       system clock, at least 10x the scl rate
//   I_reset     asynchronous active-high reset
//   scl         bus clock from the controller (input only)
//   sda         open-drain bus data (driven 0 or z)
//   I_tx_data   byte to return on a read, captured when O_tx_load pulses
//   I_rx_ready  fabric can accept a write byte; low at the 8th bit -> NACK
//   O_rx_data   last received write byte
//   O_rx_valid  1-cycle pulse, O_rx_data has just been updated
//   O_tx_load   1-cycle pulse, I_tx_data captured; fabric advances
//   O_busy      addressed transfer in progress
//   O_rw        R/W bit of the current (last matched) transfer
//   O_start     1-cycle pulse on START / repeated START
//   O_stop      1-cycle pulse on STOP
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h1E,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       I_clk,
    input  logic       I_reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] I_tx_data,
    input  logic       I_rx_ready,
    output logic [7:0] O_rx_data,
    output logic       O_rx_valid,
    output logic       O_tx_load,
    output logic       O_busy,
    output logic       O_rw,
    output logic       O_start,
    output logic       O_stop
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_RX_BYTE  = 3'd3;
    localparam logic [2:0] ST_RX_ACK   = 3'd4;
    localparam logic [2:0] ST_TX_BYTE  = 3'd5;
    localparam logic [2:0] ST_TX_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   sda_rise;
    logic                   sda_fall;
    logic                   start_det;
    logic                   stop_det;

    logic [2:0]             state;
    logic [2:0]             bit_cnt;
    logic                   phase;
    logic [7:0]             shift_reg;
    logic                   ack_en;
    logic                   sda_oe;

    // Open-drain output: a 1 is sent by letting the pull-up win. The enable
    // comes straight from a flop so an async reset releases the line at once.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Synchronizer chains plus one history flop per line. They reset to 1
    // (idle bus level) so leaving reset on an idle bus produces no false
    // edge and in particular no phantom STOP.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign sda_rise  =  sda_s & ~sda_d;
    assign sda_fall  = ~sda_s &  sda_d;
    // The target only moves sda while scl is low, so an sda edge seen with
    // scl high can only come from the controller signalling START/STOP.
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;

    // Protocol engine. START/STOP are checked first so they override any
    // state and any scl edge in the same cycle. Bits are sampled on scl_rise
    // and sda is only changed on scl_fall. 'phase' tells the two scl falls of
    // an ACK slot apart: the first one drives the ACK, the second ends it.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            phase      <= 1'b0;
            shift_reg  <= 8'h00;
            ack_en     <= 1'b0;
            sda_oe     <= 1'b0;
            O_rx_data  <= 8'h00;
            O_rx_valid <= 1'b0;
            O_tx_load  <= 1'b0;
            O_busy     <= 1'b0;
            O_rw       <= 1'b0;
            O_start    <= 1'b0;
            O_stop     <= 1'b0;
        end else begin
            O_rx_valid <= 1'b0;
            O_tx_load  <= 1'b0;
            O_start    <= 1'b0;
            O_stop     <= 1'b0;

            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 3'd0;
                phase   <= 1'b0;
                sda_oe  <= 1'b0;
                O_busy  <= 1'b0;
                O_start <= 1'b1;
            end else if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
                phase   <= 1'b0;
                sda_oe  <= 1'b0;
                O_busy  <= 1'b0;
                O_stop  <= 1'b1;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            if (bit_cnt == 3'd7) begin
                                // shift_reg[6:0] holds the seven address bits,
                                // the bit arriving now is R/W.
                                if (shift_reg[6:0] == ADDR) begin
                                    O_rw   <= sda_s;
                                    O_busy <= 1'b1;
                                    phase  <= 1'b0;
                                    state  <= ST_ADDR_ACK;
                                end else begin
                                    state  <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                                phase  <= 1'b1;
                            end else if (!O_rw) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= ST_RX_BYTE;
                            end else begin
                                O_tx_load <= 1'b1;
                                shift_reg <= I_tx_data;
                                sda_oe    <= ~I_tx_data[7];
                                bit_cnt   <= 3'd0;
                                state     <= ST_TX_BYTE;
                            end
                        end
                    end

                    ST_RX_BYTE: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            if (bit_cnt == 3'd7) begin
                                O_rx_data  <= {shift_reg[6:0], sda_s};
                                O_rx_valid <= 1'b1;
                                ack_en     <= I_rx_ready;
                                phase      <= 1'b0;
                                bit_cnt    <= 3'd0;
                                state      <= ST_RX_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    ST_RX_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= ack_en;
                                phase  <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd0;
                                state   <= ST_RX_BYTE;
                            end
                        end
                    end

                    ST_TX_BYTE: begin
                        // bit_cnt counts bits already clocked out; after the
                        // fall that ends bit0 the line is handed back.
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                phase  <= 1'b0;
                                state  <= ST_TX_ACK;
                            end else begin
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                sda_oe    <= ~shift_reg[6];
                                bit_cnt   <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    ST_TX_ACK: begin
                        if (scl_rise && !phase) begin
                            if (sda_s) begin
                                O_busy <= 1'b0;
                                state  <= ST_IGNORE;
                            end else begin
                                phase  <= 1'b1;
                            end
                        end else if (scl_fall && phase) begin
                            O_tx_load <= 1'b1;
                            shift_reg <= I_tx_data;
                            sda_oe    <= ~I_tx_data[7];
                            bit_cnt   <= 3'd0;
                            state     <= ST_TX_BYTE;
                        end
                    end

                    default: begin
                        // IDLE and IGNORE wait for START/STOP only.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bench for i2c_target. The bench plays the I2C
// controller on an open-drain bus with a pull-up, and keeps a transaction
// level model (expected write bytes, queue of read bytes, pulse counters)
// that one monitor process checks against the DUT every cycle.
module tb_i2c_target;

    localparam int Q = 10;

    logic       I_clk = 1'b0;
    logic       I_reset;
    logic       scl;
    logic [7:0] I_tx_data;
    logic       I_rx_ready;
    logic [7:0] O_rx_data;
    logic       O_rx_valid;
    logic       O_tx_load;
    logic       O_busy;
    logic       O_rw;
    logic       O_start;
    logic       O_stop;

    wire        sda;
    logic       ctrl_low;

    assign sda = ctrl_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target #(.ADDR(7'h1E), .SYNC_STAGES(2)) dut (
        .I_clk      (I_clk),
        .I_reset    (I_reset),
        .scl        (scl),
        .sda        (sda),
        .I_tx_data  (I_tx_data),
        .I_rx_ready (I_rx_ready),
        .O_rx_data  (O_rx_data),
        .O_rx_valid (O_rx_valid),
        .O_tx_load  (O_tx_load),
        .O_busy     (O_busy),
        .O_rw       (O_rw),
        .O_start    (O_start),
        .O_stop     (O_stop)
    );

    always #5 I_clk = ~I_clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_q[$];
    int         cnt_rx = 0, cnt_tx = 0, cnt_start = 0, cnt_stop = 0;
    logic       expect_quiet = 1'b0;
    logic       quiet_all    = 1'b0;
    logic       prev_rxv = 1'b0, prev_txl = 1'b0, prev_sta = 1'b0, prev_sto = 1'b0;

    // One comparison: counts it and reports a failure on a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // The model's view of the target: an address byte is acknowledged only
    // when its upper seven bits name our target.
    function automatic logic addrAck(input logic [7:0] a);
        return a[7:1] == 7'h1E;
    endfunction

    task automatic waitClk(input int n);
        repeat (n) @(posedge I_clk);
        #2;
    endtask

    // Set the controller's scl level and sda pull-down, then hold a quarter bit.
    task automatic applyStimulus(input logic scl_v, input logic low_v);
        scl      = scl_v;
        ctrl_low = low_v;
        waitClk(Q);
    endtask

    task automatic setTx();
        I_tx_data = (tx_q.size() != 0) ? tx_q[0] : 8'hFF;
    endtask

    // One bit slot: data set while scl low, bus sampled mid scl-high.
    task automatic writeBit(input logic b, output logic s);
        applyStimulus(1'b0, ~b);
        applyStimulus(1'b1, ~b);
        s = sda;
        applyStimulus(1'b1, ~b);
        applyStimulus(1'b0, ~b);
    endtask

    task automatic busStart();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
    endtask

    task automatic busStop();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
    endtask

    task automatic writeByte(input logic [7:0] d, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            expect_quiet = 1'b1;
            writeBit(d[i], s);
        end
        expect_quiet = quiet_all;
        writeBit(1'b1, s);
        acked = (s == 1'b0);
    endtask

    task automatic readByte(input logic ack_it, output logic [7:0] d);
        logic s;
        expect_quiet = quiet_all;
        for (int i = 7; i >= 0; i--) begin
            writeBit(1'b1, s);
            d[i] = s;
        end
        writeBit(~ack_it, s);
    endtask

    // Per-cycle compare against the model: every rx pulse must deliver the
    // next expected byte, every tx load must consume a queued byte, all
    // pulses are one cycle wide, and the target stays off sda while the
    // controller owns a bit.
    always @(negedge I_clk) begin
        if (!I_reset) begin
            if (O_rx_valid) begin
                cnt_rx++;
                checkOutput("rx_valid_width", {31'd0, prev_rxv}, 0);
                checkOutput("rx_pending", {31'd0, exp_rx_q.size() != 0}, 1);
                if (exp_rx_q.size() != 0)
                    checkOutput("rx_data", {24'd0, O_rx_data}, {24'd0, exp_rx_q.pop_front()});
            end
            if (O_tx_load) begin
                cnt_tx++;
                checkOutput("tx_load_width", {31'd0, prev_txl}, 0);
                checkOutput("tx_pending", {31'd0, tx_q.size() != 0}, 1);
                if (tx_q.size() != 0) void'(tx_q.pop_front());
                setTx();
            end
            if (O_start) begin
                cnt_start++;
                checkOutput("start_width", {31'd0, prev_sta}, 0);
            end
            if (O_stop) begin
                cnt_stop++;
                checkOutput("stop_width", {31'd0, prev_sto}, 0);
            end
            if (expect_quiet && scl && !ctrl_low)
                checkOutput("sda_quiet", {31'd0, sda}, 1);
        end
        prev_rxv = O_rx_valid;
        prev_txl = O_tx_load;
        prev_sta = O_start;
        prev_sto = O_stop;
    end

    initial begin
        logic       a;
        logic [7:0] d;
        int         rx0, tx0, st0, sp0;

        I_reset    = 1'b1;
        scl        = 1'b1;
        ctrl_low   = 1'b0;
        I_rx_ready = 1'b1;
        I_tx_data  = 8'hFF;
        waitClk(4);
        checkOutput("reset_outputs",
                    {19'd0, O_rx_data, O_rx_valid, O_tx_load, O_busy, O_rw, O_start}, 0);
        checkOutput("reset_stop", {31'd0, O_stop}, 0);
        checkOutput("reset_sda", {31'd0, sda}, 1);
        I_reset = 1'b0;
        waitClk(5);
        checkOutput("idle_no_stop", cnt_stop, 0);

        // Write one byte.
        $display("[TB] write 1 byte");
        busStart();
        writeByte(8'h3C, a);
        checkOutput("t1_addr_ack", {31'd0, a}, {31'd0, addrAck(8'h3C)});
        checkOutput("t1_busy", {31'd0, O_busy}, 1);
        checkOutput("t1_rw", {31'd0, O_rw}, 0);
        exp_rx_q.push_back(8'hA5);
        writeByte(8'hA5, a);
        checkOutput("t1_data_ack", {31'd0, a}, 1);
        busStop();
        waitClk(4);
        checkOutput("t1_busy_end", {31'd0, O_busy}, 0);
        checkOutput("t1_rx_count", cnt_rx, 1);
        checkOutput("t1_rx_data", {24'd0, O_rx_data}, 32'hA5);
        checkOutput("t1_start_count", cnt_start, 1);
        checkOutput("t1_stop_count", cnt_stop, 1);

        // Read two bytes, ACK then NACK.
        $display("[TB] read 2 bytes");
        tx0 = cnt_tx;
        tx_q.push_back(8'h5A);
        tx_q.push_back(8'hC3);
        setTx();
        busStart();
        writeByte(8'h3D, a);
        checkOutput("t2_addr_ack", {31'd0, a}, {31'd0, addrAck(8'h3D)});
        checkOutput("t2_rw", {31'd0, O_rw}, 1);
        checkOutput("t2_busy", {31'd0, O_busy}, 1);
        readByte(1'b1, d);
        checkOutput("t2_byte1", {24'd0, d}, 32'h5A);
        readByte(1'b0, d);
        checkOutput("t2_byte2", {24'd0, d}, 32'hC3);
        checkOutput("t2_busy_after_nack", {31'd0, O_busy}, 0);
        busStop();
        waitClk(4);
        checkOutput("t2_tx_loads", cnt_tx - tx0, 2);

        // Address mismatch: target must stay silent throughout.
        $display("[TB] address mismatch");
        rx0 = cnt_rx; tx0 = cnt_tx;
        quiet_all = 1'b1;
        expect_quiet = 1'b1;
        busStart();
        writeByte(8'h40, a);
        checkOutput("t3_addr_nack", {31'd0, a}, {31'd0, addrAck(8'h40)});
        checkOutput("t3_busy", {31'd0, O_busy}, 0);
        writeByte(8'h00, a);
        checkOutput("t3_data_nack", {31'd0, a}, 0);
        busStop();
        quiet_all = 1'b0;
        expect_quiet = 1'b0;
        waitClk(4);
        checkOutput("t3_no_rx", cnt_rx - rx0, 0);
        checkOutput("t3_no_tx", cnt_tx - tx0, 0);

        // Backpressure on the second write byte.
        $display("[TB] backpressure");
        rx0 = cnt_rx;
        busStart();
        writeByte(8'h3C, a);
        checkOutput("t4_addr_ack", {31'd0, a}, 1);
        exp_rx_q.push_back(8'h11);
        writeByte(8'h11, a);
        checkOutput("t4_ack1", {31'd0, a}, 1);
        I_rx_ready = 1'b0;
        exp_rx_q.push_back(8'h22);
        writeByte(8'h22, a);
        checkOutput("t4_nack2", {31'd0, a}, 0);
        busStop();
        I_rx_ready = 1'b1;
        waitClk(4);
        checkOutput("t4_rx_count", cnt_rx - rx0, 2);
        checkOutput("t4_rx_data", {24'd0, O_rx_data}, 32'h22);

        // Repeated START: write then read.
        $display("[TB] repeated start");
        rx0 = cnt_rx; tx0 = cnt_tx; st0 = cnt_start;
        busStart();
        writeByte(8'h3C, a);
        checkOutput("t5_addr_w_ack", {31'd0, a}, 1);
        checkOutput("t5_rw_w", {31'd0, O_rw}, 0);
        exp_rx_q.push_back(8'h07);
        writeByte(8'h07, a);
        checkOutput("t5_data_ack", {31'd0, a}, 1);
        tx_q.push_back(8'h96);
        setTx();
        busStart();
        checkOutput("t5_busy_after_sr", {31'd0, O_busy}, 0);
        checkOutput("t5_rw_hold", {31'd0, O_rw}, 0);
        writeByte(8'h3D, a);
        checkOutput("t5_addr_r_ack", {31'd0, a}, 1);
        checkOutput("t5_rw_r", {31'd0, O_rw}, 1);
        readByte(1'b0, d);
        checkOutput("t5_read", {24'd0, d}, 32'h96);
        busStop();
        waitClk(4);
        checkOutput("t5_starts", cnt_start - st0, 2);
        checkOutput("t5_rx_count", cnt_rx - rx0, 1);
        checkOutput("t5_tx_count", cnt_tx - tx0, 1);

        // Reset while the target drives a 0 data bit.
        $display("[TB] reset mid-read");
        tx_q.push_back(8'h0F);
        setTx();
        busStart();
        writeByte(8'h3D, a);
        checkOutput("t6_addr_ack", {31'd0, a}, 1);
        checkOutput("t6_target_drives", {31'd0, sda}, 0);
        I_reset = 1'b1;
        #1;
        checkOutput("t6_sda_released", {31'd0, sda}, 1);
        checkOutput("t6_outputs",
                    {19'd0, O_rx_data, O_rx_valid, O_tx_load, O_busy, O_rw, O_start}, 0);
        waitClk(3);
        tx_q.delete();
        setTx();
        I_reset = 1'b0;
        waitClk(3);
        applyStimulus(1'b1, 1'b0);
        rx0 = cnt_rx;
        busStart();
        writeByte(8'h3C, a);
        checkOutput("t6_post_addr_ack", {31'd0, a}, 1);
        exp_rx_q.push_back(8'h5E);
        writeByte(8'h5E, a);
        checkOutput("t6_post_data_ack", {31'd0, a}, 1);
        busStop();
        waitClk(4);
        checkOutput("t6_post_rx_data", {24'd0, O_rx_data}, 32'h5E);
        checkOutput("t6_post_rx_count", cnt_rx - rx0, 1);
        checkOutput("rx_all_seen", exp_rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
